// File: rtl/mem_stage_ls.sv
// MEM stage: EX->MEM pipeline register, variable-latency SRAM load handling,
// sub-word load extraction, and the WB/forwarding outputs.
module mem_stage_ls #(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int SIDE_W    = 66,
  parameter int STALL_W   = 6,
  parameter int STAGE_IDX = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic                flush,
  input  logic [PC_W-1:0]     ex_pc,
  input  logic [DATA_W-1:0]   ex_result,
  input  logic                ex_rf_we,
  input  logic [4:0]          ex_rf_waddr,
  input  logic                ex_sel_rf_res,
  input  logic [2:0]          ex_mem_op,
  input  logic [SIDE_W-1:0]   ex_side,
  input  logic [DATA_W-1:0]   data_sram_rdata,
  input  logic                data_sram_rvalid,
  output logic                stallreq_mem,
  output logic                addr_err,
  output logic [PC_W-1:0]     wb_pc,
  output logic                wb_rf_we,
  output logic [4:0]          wb_rf_waddr,
  output logic [DATA_W-1:0]   wb_rf_wdata,
  output logic [SIDE_W-1:0]   wb_side,
  output logic                fwd_rf_we,
  output logic [4:0]          fwd_rf_waddr,
  output logic [DATA_W-1:0]   fwd_rf_wdata,
  output logic                fwd_load_pending
);
  localparam int OFF_W = $clog2(DATA_W/8);
  localparam logic [2:0] OP_LB = 3'd1, OP_LBU = 3'd2, OP_LH = 3'd3, OP_LHU = 3'd4, OP_LW = 3'd5;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] result;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic              sel_rf_res;
    logic [2:0]        mem_op;
    logic [SIDE_W-1:0] side;
  } stage_t;

  typedef enum logic [1:0] {IDLE, WAIT, HAVE} state_t;

  stage_t            r, nxt;
  state_t            state;
  logic [DATA_W-1:0] hold;
  logic              capture, bubble, nxt_load;

  assign capture = !stall[STAGE_IDX];
  assign bubble  = stall[STAGE_IDX] && !stall[STAGE_IDX+1];

  // Ops 6/7 are folded to "none" at capture so nothing downstream sees them.
  always_comb begin
    nxt            = '0;
    nxt.pc         = ex_pc;
    nxt.result     = ex_result;
    nxt.rf_we      = ex_rf_we;
    nxt.rf_waddr   = ex_rf_waddr;
    nxt.sel_rf_res = ex_sel_rf_res;
    nxt.mem_op     = (ex_mem_op > OP_LW) ? 3'd0 : ex_mem_op;
    nxt.side       = ex_side;
  end
  assign nxt_load = (nxt.mem_op != 3'd0) && nxt.sel_rf_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      r     <= '0;
      state <= IDLE;
      hold  <= '0;
    end else if (flush) begin
      r     <= '0;
      state <= IDLE;
    end else if (bubble) begin
      r     <= '0;
      state <= IDLE;
    end else if (capture) begin
      r     <= nxt;
      state <= nxt_load ? WAIT : IDLE;
    end else if (state == WAIT && data_sram_rvalid) begin
      state <= HAVE;
      hold  <= data_sram_rdata;
    end
  end

  // Same-cycle bypass of the response keeps load-to-use latency at zero.
  logic              take_now;
  logic [DATA_W-1:0] raw, word, ext;
  logic [OFF_W+2:0]  bidx, hidx;
  logic [7:0]        b;
  logic [15:0]       h;

  assign take_now = (state == WAIT) && data_sram_rvalid;
  assign raw      = take_now ? data_sram_rdata : hold;

  generate
    if (DATA_W > 32) begin : g_wide
      assign word = {{(DATA_W-32){raw[31]}}, raw[31:0]};
    end else begin : g_narrow
      assign word = raw;
    end
  endgenerate

  always_comb begin
    bidx    = {r.result[OFF_W-1:0], 3'b000};
    hidx    = bidx;
    hidx[3] = 1'b0;
    b       = raw[bidx +: 8];
    h       = raw[hidx +: 16];
    case (r.mem_op)
      OP_LB:   ext = {{(DATA_W-8){b[7]}}, b};
      OP_LBU:  ext = {{(DATA_W-8){1'b0}}, b};
      OP_LH:   ext = {{(DATA_W-16){h[15]}}, h};
      OP_LHU:  ext = {{(DATA_W-16){1'b0}}, h};
      OP_LW:   ext = word;
      default: ext = '0;
    endcase
  end

  assign addr_err = (((r.mem_op == OP_LH) || (r.mem_op == OP_LHU)) && r.result[0]) ||
                    ((r.mem_op == OP_LW) && (r.result[1:0] != 2'b00));

  assign stallreq_mem     = (state == WAIT) && !data_sram_rvalid;
  assign fwd_load_pending = stallreq_mem;

  assign wb_pc        = r.pc;
  assign wb_rf_we     = r.rf_we && !stallreq_mem;
  assign wb_rf_waddr  = r.rf_waddr;
  assign wb_rf_wdata  = r.sel_rf_res ? ext : r.result;
  assign wb_side      = r.side;
  assign fwd_rf_we    = wb_rf_we;
  assign fwd_rf_waddr = wb_rf_waddr;
  assign fwd_rf_wdata = wb_rf_wdata;

  logic unused_stall;
  assign unused_stall = ^stall;
endmodule
